// File: rtl/audio_adc_capture_if.sv
// Sample-pair handshake between the ADC capture block and the processor-side consumer.
// The producer drives the head pair and its valid flag; the consumer answers with ready.
interface audio_adc_capture_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] SAMPLE_L;
  logic [SAMPLE_WIDTH-1:0] SAMPLE_R;
  logic                    SAMPLE_VALID;
  logic                    SAMPLE_READY;

  modport master (
    output SAMPLE_L,
    output SAMPLE_R,
    output SAMPLE_VALID,
    input  SAMPLE_READY
  );

  modport slave (
    input  SAMPLE_L,
    input  SAMPLE_R,
    input  SAMPLE_VALID,
    output SAMPLE_READY
  );
endinterface

// File: rtl/audio_adc_capture.sv
// WM8731 ADC I2S receiver: deserialises left/right words clocked by the codec's
// bit clock and queues the pairs in a first-word-fall-through FIFO.
module audio_adc_capture #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ENABLE,
  input  logic                 AUD_BCLK,
  input  logic                 AUD_ADCLRCK,
  input  logic                 AUD_ADCDAT,
  audio_adc_capture_if.master  smp,
  output logic                 OVERFLOW,
  output logic                 FRAME_ERR
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int BCW  = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;

  logic [2:0]              bclk_sync_q, bclk_sync_d;
  logic [1:0]              lrck_sync_q, lrck_sync_d;
  logic [1:0]              dat_sync_q, dat_sync_d;
  logic                    lrck_prev_q, lrck_prev_d;
  state_t                  state_q, state_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic                    push_q, push_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overflow_q, overflow_d;

  logic [FIFO_DEPTH-1:0][SAMPLE_WIDTH-1:0] mem_l_q, mem_l_d;
  logic [FIFO_DEPTH-1:0][SAMPLE_WIDTH-1:0] mem_r_q, mem_r_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]         count_q, count_d;

  logic brise, lrck, dat, boundary;
  logic fifo_valid, fifo_full, pop, do_push;

  // LRCK and DAT are read from the same stage as the BCLK edge detector so all three stay aligned.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], AUD_BCLK};
    lrck_sync_d = {lrck_sync_q[0], AUD_ADCLRCK};
    dat_sync_d  = {dat_sync_q[0], AUD_ADCDAT};
    brise       = bclk_sync_q[1] & ~bclk_sync_q[2];
    lrck        = lrck_sync_q[1];
    dat         = dat_sync_q[1];
    lrck_prev_d = brise ? lrck : lrck_prev_q;
    boundary    = brise & (lrck ^ lrck_prev_q);
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_l_d    = hold_l_q;
    push_d      = 1'b0;
    frame_err_d = frame_err_q;
    if (!ENABLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (boundary && !lrck) state_d = SKIP;
        // The boundary brise already carried the I2S delay bit, so SHIFT starts right away.
        SKIP: begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
        SHIFT: begin
          if (boundary) begin
            frame_err_d = 1'b1;
            state_d     = lrck ? IDLE : SKIP;
          end else if (brise) begin
            shift_d   = {shift_q[SAMPLE_WIDTH-2:0], dat};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BCW'(SAMPLE_WIDTH - 1)) begin
              state_d = WAIT;
              if (lrck) push_d = 1'b1;
              else      hold_l_d = shift_d;
            end
          end
        end
        WAIT: if (boundary) state_d = SKIP;
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    fifo_valid = (count_q != '0);
    fifo_full  = (count_q == CNTW'(FIFO_DEPTH));
    pop        = fifo_valid & smp.SAMPLE_READY;
    do_push    = push_q & (~fifo_full | pop);
    mem_l_d    = mem_l_q;
    mem_r_d    = mem_r_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (do_push) begin
      mem_l_d[wr_ptr_q] = hold_l_q;
      mem_r_d[wr_ptr_q] = shift_q;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d    = count_q + CNTW'(do_push) - CNTW'(pop);
    overflow_d = overflow_q | (push_q & fifo_full & ~pop);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      lrck_prev_q <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_l_q    <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      mem_l_q     <= '0;
      mem_r_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      dat_sync_q  <= dat_sync_d;
      lrck_prev_q <= lrck_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_l_q    <= hold_l_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      mem_l_q     <= mem_l_d;
      mem_r_q     <= mem_r_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign smp.SAMPLE_VALID = fifo_valid;
  assign smp.SAMPLE_L     = fifo_valid ? mem_l_q[rd_ptr_q] : '0;
  assign smp.SAMPLE_R     = fifo_valid ? mem_r_q[rd_ptr_q] : '0;
  assign OVERFLOW         = overflow_q;
  assign FRAME_ERR        = frame_err_q;

endmodule

// File: tb/tb_audio_adc_capture.sv
// Directed bench for audio_adc_capture: drives I2S words bit by bit on a slow BCLK
// and compares the FIFO head, handshake and sticky flags against hand-computed values.
module tb_audio_adc_capture;

  localparam int SW = 16;
  localparam int FD = 4;

  logic Clk = 1'b0;
  logic Reset;
  logic ENABLE;
  logic AUD_BCLK;
  logic AUD_ADCLRCK;
  logic AUD_ADCDAT;
  logic OVERFLOW;
  logic FRAME_ERR;

  int compareCount  = 0;
  int mismatchCount = 0;

  audio_adc_capture_if #(.SAMPLE_WIDTH(SW)) smp ();

  audio_adc_capture #(
    .SAMPLE_WIDTH(SW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ENABLE     (ENABLE),
    .AUD_BCLK   (AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT (AUD_ADCDAT),
    .smp        (smp),
    .OVERFLOW   (OVERFLOW),
    .FRAME_ERR  (FRAME_ERR)
  );

  always #10 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One BCLK period: 4 Clk low then 4 Clk high, data and LRCK changing while BCLK is low.
  // mode 1 checks SAMPLE_VALID latency around this rising edge; mode 2 pops exactly on the push edge.
  task automatic driveBit(input logic l, input logic d, input int mode);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = l;
    AUD_ADCDAT  = d;
    repeat (4) @(negedge Clk);
    AUD_BCLK = 1'b1;
    repeat (3) @(negedge Clk);
    if (mode == 1) checkOutput("latency_before_push", {31'd0, smp.SAMPLE_VALID}, 32'd0);
    if (mode == 2) begin
      checkOutput("head_at_push_pop", {16'd0, smp.SAMPLE_L}, 32'd1);
      smp.SAMPLE_READY = 1'b1;
    end
    @(negedge Clk);
    if (mode == 1) checkOutput("latency_after_push", {31'd0, smp.SAMPLE_VALID}, 32'd1);
    if (mode == 2) smp.SAMPLE_READY = 1'b0;
  endtask

  // A 32-slot channel word: delay bit, 16 data bits MSB first, then padding of ones.
  task automatic sendWord(input logic l, input logic [15:0] w, input int nslots, input int lsbMode);
    for (int slot = 0; slot < nslots; slot++) begin
      if (slot == 0)       driveBit(l, 1'b1, 0);
      else if (slot <= 16) driveBit(l, w[16-slot], (slot == 16) ? lsbMode : 0);
      else                 driveBit(l, 1'b1, 0);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input int lsbMode);
    sendWord(1'b0, l, 32, 0);
    sendWord(1'b1, r, 32, lsbMode);
  endtask

  task automatic preamble();
    repeat (4) driveBit(1'b1, 1'b1, 0);
  endtask

  task automatic doReset();
    AUD_BCLK = 1'b0;
    Reset    = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic popCheck(input string tag, input logic [15:0] l, input logic [15:0] r);
    checkOutput({tag, "_valid"}, {31'd0, smp.SAMPLE_VALID}, 32'd1);
    checkOutput({tag, "_L"}, {16'd0, smp.SAMPLE_L}, {16'd0, l});
    checkOutput({tag, "_R"}, {16'd0, smp.SAMPLE_R}, {16'd0, r});
    smp.SAMPLE_READY = 1'b1;
    @(negedge Clk);
    smp.SAMPLE_READY = 1'b0;
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, smp.SAMPLE_VALID}, 32'd0);
    checkOutput({tag, "_L"}, {16'd0, smp.SAMPLE_L}, 32'd0);
    checkOutput({tag, "_R"}, {16'd0, smp.SAMPLE_R}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: time limit reached before the end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset            = 1'b1;
    ENABLE           = 1'b1;
    AUD_BCLK         = 1'b0;
    AUD_ADCLRCK      = 1'b0;
    AUD_ADCDAT       = 1'b0;
    smp.SAMPLE_READY = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    $display("[TB] reset state");
    checkEmpty("reset");
    checkOutput("reset_ovf", {31'd0, OVERFLOW}, 32'd0);
    checkOutput("reset_ferr", {31'd0, FRAME_ERR}, 32'd0);

    $display("[TB] nominal frame with latency check");
    preamble();
    applyStimulus(16'hA5C3, 16'h0F0F, 1);
    popCheck("nominal", 16'hA5C3, 16'h0F0F);
    checkEmpty("nominal_after_pop");

    $display("[TB] start alignment: reset released mid right word");
    AUD_BCLK = 1'b0;
    Reset    = 1'b1;
    repeat (4) driveBit(1'b1, 1'b1, 0);
    Reset = 1'b0;
    repeat (20) driveBit(1'b1, 1'b1, 0);
    applyStimulus(16'h1234, 16'h5678, 0);
    popCheck("align", 16'h1234, 16'h5678);
    checkEmpty("align_after_pop");

    $display("[TB] overflow with no consumer");
    doReset();
    preamble();
    for (int i = 1; i <= 4; i++) applyStimulus(16'(i), 16'(i << 8), 0);
    checkOutput("ovf_full_no_flag", {31'd0, OVERFLOW}, 32'd0);
    applyStimulus(16'd5, 16'h0500, 0);
    checkOutput("ovf_flag", {31'd0, OVERFLOW}, 32'd1);
    for (int i = 1; i <= 4; i++) popCheck("ovf_pop", 16'(i), 16'(i << 8));
    checkEmpty("ovf_drained");
    checkOutput("ovf_sticky", {31'd0, OVERFLOW}, 32'd1);

    $display("[TB] full FIFO with pop on the push edge");
    doReset();
    preamble();
    for (int i = 1; i <= 4; i++) applyStimulus(16'(i), 16'(i << 8), 0);
    applyStimulus(16'd5, 16'h0500, 2);
    checkOutput("fullpop_no_ovf", {31'd0, OVERFLOW}, 32'd0);
    for (int i = 2; i <= 5; i++) popCheck("fullpop_pop", 16'(i), 16'(i << 8));
    checkEmpty("fullpop_drained");

    $display("[TB] short left word");
    doReset();
    preamble();
    sendWord(1'b0, 16'hFFFF, 11, 0);
    checkOutput("short_before_toggle", {31'd0, FRAME_ERR}, 32'd0);
    sendWord(1'b1, 16'hAAAA, 32, 0);
    checkOutput("short_ferr", {31'd0, FRAME_ERR}, 32'd1);
    checkOutput("short_no_pair", {31'd0, smp.SAMPLE_VALID}, 32'd0);
    applyStimulus(16'hC0DE, 16'hBEEF, 0);
    popCheck("short_clean", 16'hC0DE, 16'hBEEF);
    checkEmpty("short_after_pop");
    checkOutput("short_ferr_sticky", {31'd0, FRAME_ERR}, 32'd1);

    $display("[TB] enable drop mid right word, then reset mid left word");
    doReset();
    preamble();
    applyStimulus(16'h2222, 16'h3333, 0);
    sendWord(1'b0, 16'h1111, 32, 0);
    sendWord(1'b1, 16'h9999, 9, 0);
    ENABLE = 1'b0;
    repeat (23) driveBit(1'b1, 1'b1, 0);
    checkOutput("disable_keeps_head", {16'd0, smp.SAMPLE_L}, 32'h2222);
    checkOutput("disable_no_ferr", {31'd0, FRAME_ERR}, 32'd0);
    ENABLE = 1'b1;
    applyStimulus(16'h4444, 16'h5555, 0);
    popCheck("disable_first", 16'h2222, 16'h3333);
    checkOutput("disable_next_L", {16'd0, smp.SAMPLE_L}, 32'h4444);
    checkOutput("disable_next_R", {16'd0, smp.SAMPLE_R}, 32'h5555);
    sendWord(1'b0, 16'h6666, 9, 0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checkEmpty("midreset");
    checkOutput("midreset_ovf", {31'd0, OVERFLOW}, 32'd0);
    checkOutput("midreset_ferr", {31'd0, FRAME_ERR}, 32'd0);
    repeat (23) driveBit(1'b0, 1'b1, 0);
    sendWord(1'b1, 16'hEEEE, 32, 0);
    checkOutput("midreset_no_residue", {31'd0, smp.SAMPLE_VALID}, 32'd0);
    applyStimulus(16'h7777, 16'h8888, 0);
    popCheck("midreset_clean", 16'h7777, 16'h8888);
    checkEmpty("midreset_after_pop");
    checkOutput("midreset_clean_ferr", {31'd0, FRAME_ERR}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/audio_adc_capture.md
# audio_adc_capture

Receive-side counterpart of the WM8731 playback driver. It deserialises the codec's ADC stream (I2S format, codec as bit-clock master) into 16-bit left/right sample pairs. The pairs are buffered in a small FIFO and handed to the NIOS-II through a valid/ready handshake. It sits between the WM8731 ADC pins and the processor-side sound capture path, sharing the codec's AUD_BCLK with the playback driver.

## Interface
- SAMPLE_WIDTH, 16: bits captured per channel, MSB first.
- FIFO_DEPTH, 4: number of stereo pairs buffered; power of two, at least 2.

- Clk  input  1  system clock (50 MHz); all logic is synchronous to Clk.
- Reset  input  1  reset Reset, synchronous, active-high; clock Clk.
- ENABLE  input  1  capture enable; low forces IDLE.
- AUD_BCLK  input  1  codec bit clock, asynchronous to Clk.
- AUD_ADCLRCK  input  1  codec ADC word clock, asynchronous; low = left, high = right.
- AUD_ADCDAT  input  1  codec ADC serial data, asynchronous.
- SAMPLE_L  output  SAMPLE_WIDTH  left sample at FIFO head; 0 when FIFO empty.
- SAMPLE_R  output  SAMPLE_WIDTH  right sample at FIFO head; 0 when FIFO empty.
- SAMPLE_VALID  output  1  FIFO non-empty.
- SAMPLE_READY  input  1  consumer accepts head pair.
- OVERFLOW  output  1  sticky: a completed pair was dropped because the FIFO was full.
- FRAME_ERR  output  1  sticky: a word clock edge arrived before SAMPLE_WIDTH bits were captured.

## Operation
- AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT each pass through an identical 2-flop synchroniser. A third flop on BCLK gives a rising-edge strobe `brise = s2 & ~s3`.
- All serial activity happens only on Clk cycles where brise=1. LRCK and DAT are taken from the s2 stage, so the three signals stay aligned.
- `lrck_prev` is updated on every brise. A boundary is a brise where lrck_s2 != lrck_prev.
- States:
  - IDLE: entered on Reset or ENABLE=0. Leave for SKIP on a boundary with lrck_s2=0 (the start of the left word). Capture always starts on a left word.
  - SKIP: this is the I2S one-bit delay. The boundary brise itself is the delay bit and its data is ignored. Go to SHIFT with bit count = 0.
  - SHIFT: on each brise, shift DAT into the channel shift register LSB-first-in, so the MSB ends up at the top. Increment the count.
    - When the count reaches SAMPLE_WIDTH on a left word: latch into hold_L and go to WAIT.
    - When the count reaches SAMPLE_WIDTH on a right word: push {hold_L, word} and go to WAIT.
  - WAIT: ignore padding bits until a boundary, then go to SKIP. A boundary into a left word starts a new pair.
- Short word: a boundary while in SHIFT sets FRAME_ERR. Any partial word and any held left sample are discarded. The next state is SKIP if lrck_s2=0, otherwise IDLE.
- ENABLE falling mid-frame abandons the partial frame without setting FRAME_ERR. FIFO contents are preserved.
- FIFO behaviour:
  - First-word-fall-through; SAMPLE_L and SAMPLE_R show the head pair.
  - A pop occurs on a Clk edge with SAMPLE_VALID & SAMPLE_READY.
  - A push when full with no pop in the same cycle drops the new pair and sets OVERFLOW.
  - A push and pop in the same cycle while full are both performed, and OVERFLOW is not set.
  - A push and pop in the same cycle while the FIFO holds one pair leaves one pair: the new one.
- The read and write pointers wrap modulo FIFO_DEPTH. The occupancy count is log2(FIFO_DEPTH)+1 bits wide.
- OVERFLOW and FRAME_ERR are cleared only by Reset.

## Timing
- Reset values:
  - Outputs: SAMPLE_L=0, SAMPLE_R=0, SAMPLE_VALID=0, OVERFLOW=0, FRAME_ERR=0.
  - Internal: state IDLE, FIFO empty, synchronisers 0, lrck_prev=0.
- Reset is honoured mid-frame on the next Clk edge with no residue.
- AUD_BCLK high and low phases must each last at least 3 Clk periods. The codec's 3.072 MHz BCLK against the 50 MHz Clk meets this.
- Latency: the LSB of the right word is sampled on a brise cycle. The push happens on the following Clk edge. With the FIFO initially empty, SAMPLE_VALID is high from the next cycle: 2 Clk edges after the brise cycle, and 4 Clk edges after the first Clk edge that samples AUD_BCLK high.
- After a pop, SAMPLE_VALID, SAMPLE_L and SAMPLE_R update on the same edge. SAMPLE_READY may be held high continuously.
- Sustained throughput is one pair per LRCK period. The consumer must average at least one pop per LRCK period.

## Test plan
- Nominal: serially drive L=16'hA5C3 and R=16'h0F0F in I2S format with 32 BCLK per frame. Required: SAMPLE_VALID rises with SAMPLE_L=A5C3, SAMPLE_R=0F0F; one pop with READY leaves VALID=0 and both outputs 0.
- Start alignment: release Reset while LRCK is high, mid right word. Required: that right word is ignored; the first pushed pair comes from the next left/right word pair.
- Overflow: send 5 pairs (values 1..5) with SAMPLE_READY=0 and FIFO_DEPTH=4. Required: OVERFLOW=1; popping yields 1,2,3,4, then VALID=0.
- Full with pop: with the FIFO full, hold READY high on the cycle the 5th pair pushes. Required: OVERFLOW stays 0; pairs pop as 1..5.
- Short word: toggle LRCK after 10 bits of a left word, then send a clean frame. Required: FRAME_ERR=1; only the clean pair is output.
- Mid-frame reset/disable: drop ENABLE mid right word, then re-enable, then assert Reset after bit 8. Required: no partial pair after the ENABLE drop and no error flag; after Reset all outputs are 0 and the FIFO is empty.
